mem_arbiter: RTL

//  Shares the single data-memory port between the IFU (fetch) and the LSU (load/store) of the multicycle core.
//  - Accepts one request at a time over valid/ready, forwards it to memory and tracks the outstanding access.
//  - Routes the response back to the owning requester.
//  - Aborts stalled accesses with an error response after a bounded wait.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU data-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} arb_owner_t;

    localparam logic [7:0] WMASK_WORD = 8'h0f;
    localparam logic [2:0] READOP_LW  = 3'b010;
    localparam int         TO_CNT_W   = 10;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between IFU and LSU.
// Macro ARB_RR_EN selects round-robin; otherwise the LSU has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  arb_owner_t last_owner,
    output logic       gnt_ifu,
    output logic       gnt_lsu
);

`ifdef ARB_RR_EN
    // On a tie, whoever did not win last time goes first.
    assign gnt_ifu = ifu_valid && (!lsu_valid || last_owner == OWN_LSU);
    assign gnt_lsu = lsu_valid && (!ifu_valid || last_owner == OWN_IFU);
`else
    logic unused_last;
    assign unused_last = last_owner;
    assign gnt_lsu = lsu_valid;
    assign gnt_ifu = ifu_valid && !lsu_valid;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single data-memory port between IFU and LSU, one access at a time,
// with a bounded-wait abort. Build macro ARB_RR_EN switches the pick to round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_resp_valid,
    output logic [DW-1:0] ifu_rdata,
    output logic          ifu_resp_err,

    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic          lsu_wen,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [7:0]    lsu_wmask,
    input  logic [2:0]    lsu_readop,
    output logic          lsu_resp_valid,
    output logic [DW-1:0] lsu_rdata,
    output logic          lsu_resp_err,

    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    output logic [2:0]    mem_readop,
    input  logic          mem_resp_valid,
    input  logic [DW-1:0] mem_rdata
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [7:0]    wmask;
        logic [2:0]    readop;
    } req_t;

    localparam logic [TO_CNT_W-1:0] CNT_LAST = TO_CNT_W'(MAX_WAIT - 1);

    arb_state_t          state, state_nxt;
    arb_owner_t          owner, last_owner;
    req_t                req_q;
    logic [TO_CNT_W-1:0] cnt;
    logic                gnt_ifu, gnt_lsu;
    logic                resp_take, timeout;

    mem_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_owner (last_owner),
        .gnt_ifu    (gnt_ifu),
        .gnt_lsu    (gnt_lsu)
    );

    // Ready is held low while rst is asserted so every output reads 0 in reset.
    assign ifu_req_ready = (state == IDLE) && !rst && gnt_ifu;
    assign lsu_req_ready = (state == IDLE) && !rst && gnt_lsu;

    assign resp_take = (state == WAIT) && mem_resp_valid;
    assign timeout   = (state != IDLE) && (cnt == CNT_LAST) && !resp_take;

    assign mem_req_valid = (state == REQ);
    assign mem_addr      = req_q.addr;
    assign mem_wen       = req_q.wen;
    assign mem_wdata     = req_q.wdata;
    assign mem_wmask     = req_q.wmask;
    assign mem_readop    = req_q.readop;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ifu_req_ready || lsu_req_ready) state_nxt = REQ;
            REQ:     if (timeout) state_nxt = IDLE;
                     else if (mem_req_ready) state_nxt = WAIT;
            WAIT:    if (resp_take || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            owner          <= OWN_IFU;
            last_owner     <= OWN_LSU;
            cnt            <= '0;
            req_q          <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= '0;
            lsu_resp_err   <= 1'b0;
        end else begin
            state          <= state_nxt;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;

            if (state == IDLE) begin
                cnt <= '0;
                if (lsu_req_ready) begin
                    owner      <= OWN_LSU;
                    last_owner <= OWN_LSU;
                    req_q      <= '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata,
                                    wmask: lsu_wmask, readop: lsu_readop};
                end else if (ifu_req_ready) begin
                    owner      <= OWN_IFU;
                    last_owner <= OWN_IFU;
                    req_q      <= '{addr: ifu_addr, wen: 1'b0, wdata: '0,
                                    wmask: 8'h00, readop: READOP_LW};
                end
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A response in the timeout cycle wins, so timeout already excludes it.
            if (resp_take || timeout) begin
                if (owner == OWN_IFU) begin
                    ifu_resp_valid <= 1'b1;
                    ifu_rdata      <= timeout ? '0 : mem_rdata;
                    ifu_resp_err   <= timeout;
                end else begin
                    lsu_resp_valid <= 1'b1;
                    lsu_rdata      <= (timeout || req_q.wen) ? '0 : mem_rdata;
                    lsu_resp_err   <= timeout;
                end
            end
        end
    end

endmodule
